// File: rtl/warp_issue_scoreboard_if.sv
// Issue-stage bundle: instruction-buffer heads in, issue slot out, writeback in,
// pending-table status out. The scoreboard sits on the slave side.
interface warp_issue_scoreboard_if #(
  parameter int unsigned ARCH_LEN  = 32,
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned OP_BITS   = 9,
  parameter int unsigned REG_BITS  = 8
);
  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);

  // Per-warp instruction-buffer heads, warp g at [g*W +: W]
  logic [NUM_WARPS-1:0]           ibuf_valid;
  logic [NUM_WARPS-1:0]           ibuf_ready;
  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc;
  logic [NUM_WARPS*OP_BITS-1:0]   ibuf_op;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rd;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs1;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs2;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs3;
  logic [NUM_WARPS*32-1:0]        ibuf_imm32;
  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask;

  // Single-entry issue slot
  logic                    issue_valid;
  logic                    issue_ready;
  logic [WARP_ID_BITS-1:0] issue_wid;
  logic [ARCH_LEN-1:0]     issue_pc;
  logic [OP_BITS-1:0]      issue_op;
  logic [REG_BITS-1:0]     issue_rd;
  logic [REG_BITS-1:0]     issue_rs1;
  logic [REG_BITS-1:0]     issue_rs2;
  logic [REG_BITS-1:0]     issue_rs3;
  logic [31:0]             issue_imm32;
  logic [NUM_LANES-1:0]    issue_tmask;

  // Writeback and status
  logic                    wb_valid;
  logic [WARP_ID_BITS-1:0] wb_wid;
  logic [REG_BITS-1:0]     wb_rd;
  logic [NUM_WARPS-1:0]    pending_full;

  modport master (
    output ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
           ibuf_imm32, ibuf_tmask, issue_ready, wb_valid, wb_wid, wb_rd,
    input  ibuf_ready, issue_valid, issue_wid, issue_pc, issue_op, issue_rd,
           issue_rs1, issue_rs2, issue_rs3, issue_imm32, issue_tmask, pending_full
  );

  modport slave (
    input  ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
           ibuf_imm32, ibuf_tmask, issue_ready, wb_valid, wb_wid, wb_rd,
    output ibuf_ready, issue_valid, issue_wid, issue_pc, issue_op, issue_rd,
           issue_rs1, issue_rs2, issue_rs3, issue_imm32, issue_tmask, pending_full
  );
endinterface

// File: rtl/warp_issue_scoreboard.sv
// Warp issue scoreboard: round-robin picks one hazard-free warp head per cycle,
// registers it into a single issue slot and tracks its in-flight rd per warp.
module warp_issue_scoreboard #(
  parameter int unsigned ARCH_LEN   = 32,
  parameter int unsigned NUM_WARPS  = 8,
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned OP_BITS    = 9,
  parameter int unsigned REG_BITS   = 8,
  parameter int unsigned PEND_DEPTH = 4
) (
  input logic                     clock,
  input logic                     reset,
  warp_issue_scoreboard_if.slave  bus
);
  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);

  // Unpacked heads
  logic [ARCH_LEN-1:0]  head_pc    [NUM_WARPS];
  logic [OP_BITS-1:0]   head_op    [NUM_WARPS];
  logic [REG_BITS-1:0]  head_rd    [NUM_WARPS];
  logic [REG_BITS-1:0]  head_rs1   [NUM_WARPS];
  logic [REG_BITS-1:0]  head_rs2   [NUM_WARPS];
  logic [REG_BITS-1:0]  head_rs3   [NUM_WARPS];
  logic [31:0]          head_imm32 [NUM_WARPS];
  logic [NUM_LANES-1:0] head_tmask [NUM_WARPS];

  // Pending-write table
  logic [PEND_DEPTH-1:0] pend_valid_q [NUM_WARPS];
  logic [PEND_DEPTH-1:0] pend_valid_d [NUM_WARPS];
  logic [REG_BITS-1:0]   pend_rd_q    [NUM_WARPS][PEND_DEPTH];
  logic [REG_BITS-1:0]   pend_rd_d    [NUM_WARPS][PEND_DEPTH];

  logic [NUM_WARPS-1:0]    hazard;
  logic [NUM_WARPS-1:0]    has_free;
  logic [NUM_WARPS-1:0]    eligible;
  logic [NUM_WARPS-1:0]    ibuf_ready;
  logic [WARP_ID_BITS-1:0] rr_ptr_q;
  logic [WARP_ID_BITS-1:0] scan_idx;
  logic [WARP_ID_BITS-1:0] grant_wid;
  logic                    grant_valid;
  logic                    slot_free;
  logic                    alloc_done;

  // Issue slot registers
  logic                    issue_valid_q;
  logic [WARP_ID_BITS-1:0] issue_wid_q;
  logic [ARCH_LEN-1:0]     issue_pc_q;
  logic [OP_BITS-1:0]      issue_op_q;
  logic [REG_BITS-1:0]     issue_rd_q;
  logic [REG_BITS-1:0]     issue_rs1_q;
  logic [REG_BITS-1:0]     issue_rs2_q;
  logic [REG_BITS-1:0]     issue_rs3_q;
  logic [31:0]             issue_imm32_q;
  logic [NUM_LANES-1:0]    issue_tmask_q;

  // Split the packed head buses into per-warp fields
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      head_pc[w]    = bus.ibuf_pc[w*ARCH_LEN +: ARCH_LEN];
      head_op[w]    = bus.ibuf_op[w*OP_BITS +: OP_BITS];
      head_rd[w]    = bus.ibuf_rd[w*REG_BITS +: REG_BITS];
      head_rs1[w]   = bus.ibuf_rs1[w*REG_BITS +: REG_BITS];
      head_rs2[w]   = bus.ibuf_rs2[w*REG_BITS +: REG_BITS];
      head_rs3[w]   = bus.ibuf_rs3[w*REG_BITS +: REG_BITS];
      head_imm32[w] = bus.ibuf_imm32[w*32 +: 32];
      head_tmask[w] = bus.ibuf_tmask[w*NUM_LANES +: NUM_LANES];
    end
  end

  // Hazard and eligibility against registered table state only (no wb bypass)
  always_comb begin
    hazard   = '0;
    has_free = '0;
    eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int e = 0; e < PEND_DEPTH; e++) begin
        if (pend_valid_q[w][e] &&
            ((head_rs1[w] != '0 && head_rs1[w] == pend_rd_q[w][e]) ||
             (head_rs2[w] != '0 && head_rs2[w] == pend_rd_q[w][e]) ||
             (head_rs3[w] != '0 && head_rs3[w] == pend_rd_q[w][e]) ||
             (head_rd[w]  != '0 && head_rd[w]  == pend_rd_q[w][e]))) begin
          hazard[w] = 1'b1;
        end
      end
      has_free[w] = ~&pend_valid_q[w];
      eligible[w] = bus.ibuf_valid[w] & ~hazard[w] & ((head_rd[w] == '0) | has_free[w]);
    end
  end

  assign slot_free = ~issue_valid_q | bus.issue_ready;

  // Round-robin grant: first eligible warp at or above the pointer, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_wid   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    ibuf_ready  = '0;
    if (slot_free && !reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        scan_idx = rr_ptr_q + WARP_ID_BITS'(i);
        if (!grant_valid && eligible[scan_idx]) begin
          grant_valid = 1'b1;
          grant_wid   = scan_idx;
        end
      end
    end
    if (grant_valid) ibuf_ready[grant_wid] = 1'b1;
  end

  // Table next state: writeback clears matches; allocation uses the pre-clear
  // view so a slot freed this cycle is only reused next cycle
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    alloc_done   = 1'b0;
    if (bus.wb_valid && bus.wb_rd != '0) begin
      for (int e = 0; e < PEND_DEPTH; e++) begin
        if (pend_valid_q[bus.wb_wid][e] && pend_rd_q[bus.wb_wid][e] == bus.wb_rd) begin
          pend_valid_d[bus.wb_wid][e] = 1'b0;
        end
      end
    end
    if (grant_valid && head_rd[grant_wid] != '0) begin
      for (int e = 0; e < PEND_DEPTH; e++) begin
        if (!alloc_done && !pend_valid_q[grant_wid][e]) begin
          alloc_done                  = 1'b1;
          pend_valid_d[grant_wid][e]  = 1'b1;
          pend_rd_d[grant_wid][e]     = head_rd[grant_wid];
        end
      end
    end
  end

  // Issue slot, pointer and pending table state
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid_q <= 1'b0;
      issue_wid_q   <= '0;
      issue_pc_q    <= '0;
      issue_op_q    <= '0;
      issue_rd_q    <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      issue_rs3_q   <= '0;
      issue_imm32_q <= '0;
      issue_tmask_q <= '0;
      rr_ptr_q      <= '0;
      pend_valid_q  <= '{default: '0};
      pend_rd_q     <= '{default: '0};
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      if (grant_valid) begin
        issue_valid_q <= 1'b1;
        issue_wid_q   <= grant_wid;
        issue_pc_q    <= head_pc[grant_wid];
        issue_op_q    <= head_op[grant_wid];
        issue_rd_q    <= head_rd[grant_wid];
        issue_rs1_q   <= head_rs1[grant_wid];
        issue_rs2_q   <= head_rs2[grant_wid];
        issue_rs3_q   <= head_rs3[grant_wid];
        issue_imm32_q <= head_imm32[grant_wid];
        issue_tmask_q <= head_tmask[grant_wid];
        rr_ptr_q      <= grant_wid + WARP_ID_BITS'(1);
      end else if (slot_free) begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  // Status: a warp's table is full when every entry is valid
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      bus.pending_full[w] = &pend_valid_q[w];
    end
  end

  assign bus.ibuf_ready  = ibuf_ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_wid   = issue_wid_q;
  assign bus.issue_pc    = issue_pc_q;
  assign bus.issue_op    = issue_op_q;
  assign bus.issue_rd    = issue_rd_q;
  assign bus.issue_rs1   = issue_rs1_q;
  assign bus.issue_rs2   = issue_rs2_q;
  assign bus.issue_rs3   = issue_rs3_q;
  assign bus.issue_imm32 = issue_imm32_q;
  assign bus.issue_tmask = issue_tmask_q;

endmodule

// File: tb/tb_warp_issue_scoreboard.sv
// Directed bench for warp_issue_scoreboard with hand-computed expectations.
module tb_warp_issue_scoreboard;
  logic clock;
  logic reset;
  int   n_vec;
  int   n_miscmp;

  warp_issue_scoreboard_if bus ();

  warp_issue_scoreboard dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_head(input int w, input logic [7:0] rd, input logic [7:0] rs1,
                          input logic [7:0] rs2, input logic [7:0] rs3);
    bus.ibuf_pc[w*32 +: 32]    = 32'h1000 + 32'(w*4);
    bus.ibuf_op[w*9 +: 9]      = 9'(w + 3);
    bus.ibuf_rd[w*8 +: 8]      = rd;
    bus.ibuf_rs1[w*8 +: 8]     = rs1;
    bus.ibuf_rs2[w*8 +: 8]     = rs2;
    bus.ibuf_rs3[w*8 +: 8]     = rs3;
    bus.ibuf_imm32[w*32 +: 32] = 32'hA000_0000 + 32'(w);
    bus.ibuf_tmask[w*16 +: 16] = 16'h8000 >> w;
  endtask

  initial begin
    n_vec          = 0;
    n_miscmp       = 0;
    reset          = 1'b1;
    bus.ibuf_valid = '0;
    bus.ibuf_pc    = '0;
    bus.ibuf_op    = '0;
    bus.ibuf_rd    = '0;
    bus.ibuf_rs1   = '0;
    bus.ibuf_rs2   = '0;
    bus.ibuf_rs3   = '0;
    bus.ibuf_imm32 = '0;
    bus.ibuf_tmask = '0;
    bus.issue_ready = 1'b1;
    bus.wb_valid   = 1'b0;
    bus.wb_wid     = '0;
    bus.wb_rd      = '0;

    // Reset state, ibuf_ready held low while reset is high
    for (int w = 0; w < 8; w++) set_head(w, 8'd0, 8'd0, 8'd0, 8'd0);
    bus.ibuf_valid = 8'hFF;
    tick();
    tick();
    check_eq("rst_ready", 64'(bus.ibuf_ready), 64'h00);
    check_eq("rst_issue_valid", 64'(bus.issue_valid), 64'h0);
    check_eq("rst_issue_pc", 64'(bus.issue_pc), 64'h0);
    check_eq("rst_pending_full", 64'(bus.pending_full), 64'h00);

    // Round robin over all warps, one issue per cycle
    reset = 1'b0;
    settle();
    for (int k = 0; k < 9; k++) begin
      check_eq("rr_ready", 64'(bus.ibuf_ready), 64'(8'h01 << (k % 8)));
      tick();
      check_eq("rr_valid", 64'(bus.issue_valid), 64'h1);
      check_eq("rr_wid", 64'(bus.issue_wid), 64'(k % 8));
      check_eq("rr_pc", 64'(bus.issue_pc), 64'(32'h1000 + 32'((k % 8) * 4)));
      check_eq("rr_imm", 64'(bus.issue_imm32), 64'(32'hA000_0000 + 32'(k % 8)));
      check_eq("rr_tmask", 64'(bus.issue_tmask), 64'(16'h8000 >> (k % 8)));
    end
    bus.ibuf_valid = '0;
    settle();
    check_eq("idle_ready", 64'(bus.ibuf_ready), 64'h00);
    tick();
    check_eq("idle_valid_drop", 64'(bus.issue_valid), 64'h0);

    // RAW hazard on warp 2 until writeback (pointer now 1)
    set_head(2, 8'd5, 8'd0, 8'd0, 8'd0);
    bus.ibuf_valid = 8'h04;
    settle();
    check_eq("w2_first_ready", 64'(bus.ibuf_ready), 64'h04);
    tick();
    check_eq("w2_first_rd", 64'(bus.issue_rd), 64'd5);
    set_head(2, 8'd0, 8'd5, 8'd0, 8'd0);
    set_head(3, 8'd0, 8'd0, 8'd0, 8'd0);
    set_head(4, 8'd0, 8'd0, 8'd0, 8'd0);
    bus.ibuf_valid = 8'h1C;
    settle();
    check_eq("haz_skip_w2_a", 64'(bus.ibuf_ready), 64'h08);
    tick();
    check_eq("haz_wid3", 64'(bus.issue_wid), 64'd3);
    check_eq("haz_skip_w2_b", 64'(bus.ibuf_ready), 64'h10);
    tick();
    check_eq("haz_wid4", 64'(bus.issue_wid), 64'd4);
    bus.ibuf_valid = 8'h04;
    bus.wb_valid   = 1'b1;
    bus.wb_wid     = 3'd2;
    bus.wb_rd      = 8'd5;
    settle();
    check_eq("haz_no_bypass", 64'(bus.ibuf_ready), 64'h00);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    check_eq("haz_bubble", 64'(bus.issue_valid), 64'h0);
    check_eq("haz_cleared_ready", 64'(bus.ibuf_ready), 64'h04);
    tick();
    check_eq("haz_w2_issue", 64'(bus.issue_wid), 64'd2);
    check_eq("haz_w2_rs1", 64'(bus.issue_rs1), 64'd5);

    // Fill warp 0 table (pointer now 3)
    bus.ibuf_valid = 8'h01;
    for (int r = 1; r <= 4; r++) begin
      set_head(0, 8'(r), 8'd0, 8'd0, 8'd0);
      settle();
      check_eq("fill_ready", 64'(bus.ibuf_ready), 64'h01);
      tick();
      check_eq("fill_rd", 64'(bus.issue_rd), 64'(r));
    end
    check_eq("full_w0", 64'(bus.pending_full), 64'h01);
    set_head(0, 8'd6, 8'd0, 8'd0, 8'd0);
    settle();
    check_eq("full_stall", 64'(bus.ibuf_ready), 64'h00);
    tick();
    check_eq("full_bubble", 64'(bus.issue_valid), 64'h0);
    set_head(0, 8'd0, 8'd7, 8'd0, 8'd0);
    settle();
    check_eq("full_rd0_ready", 64'(bus.ibuf_ready), 64'h01);
    tick();
    check_eq("full_rd0_rs1", 64'(bus.issue_rs1), 64'd7);
    check_eq("full_rd0_rd", 64'(bus.issue_rd), 64'd0);

    // Backpressure: slot holds, no dequeue (pointer now 1)
    bus.ibuf_valid = 8'h60;
    set_head(5, 8'd0, 8'd0, 8'd0, 8'd0);
    set_head(6, 8'd0, 8'd0, 8'd0, 8'd0);
    bus.issue_ready = 1'b0;
    settle();
    check_eq("bp_ready0", 64'(bus.ibuf_ready), 64'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("bp_valid", 64'(bus.issue_valid), 64'h1);
      check_eq("bp_wid", 64'(bus.issue_wid), 64'd0);
      check_eq("bp_rs1", 64'(bus.issue_rs1), 64'd7);
      check_eq("bp_ready", 64'(bus.ibuf_ready), 64'h00);
    end
    bus.issue_ready = 1'b1;
    settle();
    check_eq("bp_release", 64'(bus.ibuf_ready), 64'h20);
    tick();
    check_eq("bp_next_wid", 64'(bus.issue_wid), 64'd5);

    // Warp 1: three allocations, then writeback and allocation together
    bus.ibuf_valid = 8'h02;
    for (int j = 0; j < 3; j++) begin
      set_head(1, (j == 0) ? 8'd3 : 8'(9 + j), 8'd0, 8'd0, 8'd0);
      settle();
      check_eq("w1_alloc_ready", 64'(bus.ibuf_ready), 64'h02);
      tick();
    end
    check_eq("w1_not_full", 64'(bus.pending_full), 64'h01);
    set_head(1, 8'd9, 8'd0, 8'd0, 8'd0);
    bus.wb_valid = 1'b1;
    bus.wb_wid   = 3'd1;
    bus.wb_rd    = 8'd3;
    settle();
    check_eq("same_cyc_ready", 64'(bus.ibuf_ready), 64'h02);
    tick();
    bus.wb_valid = 1'b0;
    check_eq("same_cyc_rd", 64'(bus.issue_rd), 64'd9);
    check_eq("same_cyc_full", 64'(bus.pending_full), 64'h01);
    set_head(1, 8'd0, 8'd9, 8'd0, 8'd0);
    settle();
    check_eq("rd9_pending", 64'(bus.ibuf_ready), 64'h00);
    set_head(1, 8'd0, 8'd3, 8'd0, 8'd0);
    settle();
    check_eq("rd3_cleared", 64'(bus.ibuf_ready), 64'h02);
    set_head(1, 8'd0, 8'd0, 8'd0, 8'd11);
    settle();
    check_eq("rs3_hazard", 64'(bus.ibuf_ready), 64'h00);
    set_head(1, 8'd12, 8'd0, 8'd0, 8'd0);
    settle();
    check_eq("reuse_ready", 64'(bus.ibuf_ready), 64'h02);
    tick();
    check_eq("w1_full", 64'(bus.pending_full), 64'h03);

    // Reset mid-flight clears slot, table and pointer (pointer now 2)
    set_head(0, 8'd6, 8'd0, 8'd0, 8'd0);
    set_head(1, 8'd13, 8'd0, 8'd0, 8'd0);
    set_head(4, 8'd0, 8'd0, 8'd0, 8'd0);
    bus.ibuf_valid = 8'h13;
    settle();
    check_eq("pre_rst_ready", 64'(bus.ibuf_ready), 64'h10);
    reset = 1'b1;
    settle();
    check_eq("in_rst_ready", 64'(bus.ibuf_ready), 64'h00);
    tick();
    check_eq("post_rst_valid", 64'(bus.issue_valid), 64'h0);
    check_eq("post_rst_rd", 64'(bus.issue_rd), 64'h0);
    check_eq("post_rst_full", 64'(bus.pending_full), 64'h00);
    reset = 1'b0;
    settle();
    check_eq("post_rst_ready", 64'(bus.ibuf_ready), 64'h01);
    tick();
    check_eq("post_rst_wid", 64'(bus.issue_wid), 64'd0);
    check_eq("post_rst_issue_rd", 64'(bus.issue_rd), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
